regfile_writeback: RTL and testbench

- Producer side of the register-file write port. Drives the port's write enable, destination address and write data.
- Merges two result sources: single-cycle ALU results, which never stall, and load results from the data-memory interface under a valid/ready handshake.
- Aligns and extends load data, buffers loads in a 2-entry FIFO, and keeps a pending-load scoreboard for the hazard logic.

---
 rtl/wb_pkg.sv | 19 +
 rtl/load_align.sv | 28 ++
 rtl/regfile_writeback.sv | 130 +++++++++++++
 tb/tb_regfile_writeback.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types: load funct3 codes, data width default, load-queue entry.
// Pure declarations; no timing or flow control.
package wb_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int RD_W         = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [RD_W-1:0]         rd;
        logic [XLEN_DEFAULT-1:0] data;
    } lq_entry_t;

    localparam int LQ_ENTRY_W = RD_W + XLEN_DEFAULT;
endpackage

// File: rtl/load_align.sv
// Load data aligner/extender: combinational, zero latency.
// No flow control; output follows inputs directly.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[8*off_i +: 8];
    assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write producer: ALU and load results merged, 1-cycle registered latency.
// ALU never stalls; loads back-pressured via ld_ready_o once the load queue is full.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int XLEN     = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [4:0]      ld_rd_i,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_off_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    input  logic            issue_ld_i,
    input  logic [4:0]      issue_rd_i,
    output logic            wr_en_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic [31:0]     busy_o
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lq_entry_t        lq_q [LQ_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]  wr_data_q, wr_data_d;
    logic [31:0]      busy_q, busy_d;

    logic [XLEN-1:0]  ld_aligned;
    logic             ld_acc, lq_empty;
    logic             enq, deq;
    logic             sel_vld, sel_is_ld;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;
    lq_entry_t        enq_entry;

    load_align #(.XLEN(XLEN)) u_align (
        .funct3_i (ld_funct3_i),
        .off_i    (ld_off_i),
        .rdata_i  (ld_rdata_i),
        .data_o   (ld_aligned)
    );

    // Ready depends on occupancy only, so the memory side never sees a comb loop.
    assign ld_ready_o = (cnt_q != CNT_W'(LQ_DEPTH));
    assign ld_acc     = ld_valid_i & ld_ready_o;
    assign lq_empty   = (cnt_q == '0);
    assign enq_entry  = '{rd: ld_rd_i, data: ld_aligned};

    always_comb begin
        enq       = 1'b0;
        deq       = 1'b0;
        sel_vld   = 1'b0;
        sel_is_ld = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_valid_i) begin
            sel_vld  = 1'b1;
            sel_rd   = alu_rd_i;
            sel_data = alu_data_i;
            enq      = ld_acc;
        end else if (!lq_empty) begin
            deq       = 1'b1;
            sel_vld   = 1'b1;
            sel_is_ld = 1'b1;
            sel_rd    = lq_q[head_q].rd;
            sel_data  = lq_q[head_q].data;
            enq       = ld_acc;
        end else if (ld_acc) begin
            sel_vld   = 1'b1;
            sel_is_ld = 1'b1;
            sel_rd    = ld_rd_i;
            sel_data  = ld_aligned;
        end
    end

    always_comb begin
        head_d = deq ? head_q + PTR_W'(1) : head_q;
        tail_d = enq ? tail_q + PTR_W'(1) : tail_q;
        cnt_d  = cnt_q + CNT_W'(enq) - CNT_W'(deq);

        // rd=0 still consumes the slot but never asserts the write.
        wr_en_d   = sel_vld & (sel_rd != 5'd0);
        rd_addr_d = sel_vld ? sel_rd : rd_addr_q;
        wr_data_d = sel_vld ? sel_data : wr_data_q;

        busy_d = busy_q;
        if (sel_vld && sel_is_ld) busy_d[sel_rd] = 1'b0;
        if (issue_ld_i)           busy_d[issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) lq_q[tail_q] <= enq_entry;
    end

    assign wr_en_o   = wr_en_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: alignment table, directed corner sequences, random traffic
// checked against a queue-based reference model.
module tb_regfile_writeback;
    import wb_pkg::*;

    localparam int LQ_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [4:0]  ld_rd_i;
    logic [2:0]  ld_funct3_i;
    logic [1:0]  ld_off_i;
    logic [31:0] ld_rdata_i;
    logic        issue_ld_i;
    logic [4:0]  issue_rd_i;
    logic        wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] wr_data_o;
    logic [31:0] busy_o;

    regfile_writeback #(.LQ_DEPTH(LQ_DEPTH), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i),
        .ld_funct3_i(ld_funct3_i), .ld_off_i(ld_off_i), .ld_rdata_i(ld_rdata_i),
        .issue_ld_i(issue_ld_i), .issue_rd_i(issue_rd_i),
        .wr_en_o(wr_en_o), .rd_addr_o(rd_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state: what the outputs should hold after the next edge.
    lq_entry_t   mq[$];
    logic        m_wr_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_busy;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic [31:0] exp;
    } al_vec_t;
    al_vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] m_align(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        int unsigned b, h;
        int          v;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * off[1])) % 65536;
        case (f3)
            3'd0: begin v = (b > 127) ? int'(b) - 256 : int'(b); return 32'(v); end
            3'd1: begin v = (h > 32767) ? int'(h) - 65536 : int'(h); return 32'(v); end
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic idle();
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        ld_valid_i = 0; ld_rd_i = 0; ld_funct3_i = 0; ld_off_i = 0; ld_rdata_i = 0;
        issue_ld_i = 0; issue_rd_i = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_wr_en = 0; m_rd = 0; m_data = 0; m_busy = 0;
    endtask

    // Advance one clock: check ready, update the model from current inputs, compare after edge.
    task automatic step(input string tag);
        bit          rdy, acc, take, leave;
        logic [4:0]  trd;
        logic [31:0] tdat, a;
        lq_entry_t   e, ne;
        rdy = (mq.size() < LQ_DEPTH);
        chk({tag, "_ready"}, {31'b0, ld_ready_o}, {31'b0, rdy});
        if (rst) begin
            model_reset();
        end else begin
            acc = ld_valid_i && rdy;
            a = m_align(ld_funct3_i, ld_off_i, ld_rdata_i);
            ne.rd = ld_rd_i; ne.data = a;
            take = 0; leave = 0; trd = 0; tdat = 0;
            if (alu_valid_i) begin
                take = 1; trd = alu_rd_i; tdat = alu_data_i;
                if (acc) mq.push_back(ne);
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                take = 1; leave = 1; trd = e.rd; tdat = e.data;
                if (acc) mq.push_back(ne);
            end else if (acc) begin
                take = 1; leave = 1; trd = ld_rd_i; tdat = a;
            end
            m_wr_en = take && (trd != 0);
            if (take) begin m_rd = trd; m_data = tdat; end
            if (leave) m_busy[trd] = 1'b0;
            if (issue_ld_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_wr_en"}, {31'b0, wr_en_o}, {31'b0, m_wr_en});
        if (m_wr_en) begin
            chk({tag, "_rd"}, {27'b0, rd_addr_o}, {27'b0, m_rd});
            chk({tag, "_data"}, wr_data_o, m_data);
        end
        chk({tag, "_busy"}, busy_o, m_busy);
    endtask

    initial begin
        tv[0] = '{3'b000, 2'd2, 32'h80F07F01, 32'hFFFFFFF0};
        tv[1] = '{3'b100, 2'd1, 32'h80F07F01, 32'h0000007F};
        tv[2] = '{3'b001, 2'd2, 32'h80F07F01, 32'hFFFF80F0};
        tv[3] = '{3'b101, 2'd0, 32'h80F07F01, 32'h00007F01};
        tv[4] = '{3'b010, 2'd0, 32'h80F07F01, 32'h80F07F01};
        tv[5] = '{3'b010, 2'd3, 32'h80F07F01, 32'h80F07F01};
        tv[6] = '{3'b011, 2'd1, 32'h12345678, 32'h12345678};
        tv[7] = '{3'b000, 2'd3, 32'h7F000000, 32'h0000007F};

        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_wr_en", {31'b0, wr_en_o}, 32'd0);
        chk("rst_rd_addr", {27'b0, rd_addr_o}, 32'd0);
        chk("rst_wr_data", wr_data_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_ready", {31'b0, ld_ready_o}, 32'd1);
        rst = 0;
        step("idle");

        // ALU write visible one cycle later
        alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'h1234;
        step("alu");
        chk("alu_exp_en", {31'b0, wr_en_o}, 32'd1);
        chk("alu_exp_rd", {27'b0, rd_addr_o}, 32'd5);
        chk("alu_exp_data", wr_data_o, 32'h00001234);
        idle();
        step("alu_off");
        chk("wr_en_drop", {31'b0, wr_en_o}, 32'd0);

        // Alignment table via bypassed loads
        foreach (tv[i]) begin
            ld_valid_i = 1; ld_rd_i = 1; ld_funct3_i = tv[i].f3;
            ld_off_i = tv[i].off; ld_rdata_i = tv[i].rdata;
            step("align");
            chk("align_tbl", wr_data_o, tv[i].exp);
            idle();
        end
        step("align_idle");

        // Conflict and queue fill under ALU priority
        alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h33;
        ld_valid_i = 1; ld_rd_i = 4; ld_funct3_i = F3_LW; ld_rdata_i = 32'h44;
        step("cf0");
        chk("cf_rd3", {27'b0, rd_addr_o}, 32'd3);
        alu_rd_i = 10; ld_rd_i = 6; ld_rdata_i = 32'h66;
        step("cf1");
        alu_rd_i = 11; ld_rd_i = 7; ld_rdata_i = 32'h77;
        chk("cf_full_ready", {31'b0, ld_ready_o}, 32'd0);
        step("cf2");
        alu_rd_i = 12;
        step("cf3");
        alu_valid_i = 0;
        step("cf4");
        chk("cf_rd4", {27'b0, rd_addr_o}, 32'd4);
        step("cf5");
        chk("cf_rd6", {27'b0, rd_addr_o}, 32'd6);
        idle();
        step("cf6");
        chk("cf_rd7", {27'b0, rd_addr_o}, 32'd7);
        chk("cf_data7", wr_data_o, 32'h77);
        step("cf7");

        // Scoreboard set/clear/set-wins
        issue_ld_i = 1; issue_rd_i = 9;
        step("sb_issue");
        chk("sb_set9", {31'b0, busy_o[9]}, 32'd1);
        idle();
        ld_valid_i = 1; ld_rd_i = 9; ld_funct3_i = F3_LW; ld_rdata_i = 32'h99;
        step("sb_wb");
        chk("sb_clr9", {31'b0, busy_o[9]}, 32'd0);
        idle();
        issue_ld_i = 1; issue_rd_i = 9;
        step("sb_reissue");
        ld_valid_i = 1; ld_rd_i = 9; ld_funct3_i = F3_LW;
        step("sb_both");
        chk("sb_setwins", {31'b0, busy_o[9]}, 32'd1);
        idle();
        ld_valid_i = 1; ld_rd_i = 9;
        step("sb_drain");
        idle();

        // rd=0 never writes and never marks busy
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'hFFFFFFFF;
        step("r0_alu");
        chk("r0_alu_en", {31'b0, wr_en_o}, 32'd0);
        idle();
        ld_valid_i = 1; ld_rd_i = 0; issue_ld_i = 1; issue_rd_i = 0;
        chk("r0_ld_ready", {31'b0, ld_ready_o}, 32'd1);
        step("r0_ld");
        chk("r0_ld_en", {31'b0, wr_en_o}, 32'd0);
        chk("r0_busy", busy_o, 32'd0);
        idle();

        // Reset with two loads queued
        issue_ld_i = 1; issue_rd_i = 20;
        step("mr_i0");
        issue_rd_i = 21;
        step("mr_i1");
        idle();
        alu_valid_i = 1; alu_rd_i = 2; ld_valid_i = 1; ld_rd_i = 20;
        step("mr_q0");
        ld_rd_i = 21;
        step("mr_q1");
        chk("mr_qfull", {31'b0, ld_ready_o}, 32'd0);
        idle();
        rst = 1;
        step("mr_rst0");
        step("mr_rst1");
        rst = 0;
        chk("mr_busy", busy_o, 32'd0);
        chk("mr_ready", {31'b0, ld_ready_o}, 32'd1);
        repeat (3) step("mr_idle");

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            alu_valid_i = ($urandom_range(0, 2) == 0);
            alu_rd_i    = 5'($urandom);
            alu_data_i  = $urandom;
            ld_valid_i  = ($urandom_range(0, 1) == 0);
            ld_rd_i     = 5'($urandom);
            ld_funct3_i = 3'($urandom);
            ld_off_i    = 2'($urandom);
            ld_rdata_i  = $urandom;
            issue_ld_i  = ($urandom_range(0, 2) == 0);
            issue_rd_i  = 5'($urandom);
            step("rnd");
        end
        rst = 0;
        idle();
        repeat (4) step("tail");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
